// File: rtl/dma_mem_bridge.sv
// dma_mem_bridge: arbitrates the data-memory bus between the CPU and the DMA,
// and writes each DMA line captured during a grant to memory as a word burst.
module dma_mem_bridge #(
  parameter int WORD_SIZE      = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int CNT_W          = 8
) (
  input  logic                                CLK,
  input  logic                                reset,
  input  logic                                BR,
  output logic                                BG,
  input  logic                                dma_write,
  input  logic [WORD_SIZE-1:0]                dma_addr,
  input  logic [WORDS_PER_LINE*WORD_SIZE-1:0] dma_data,
  input  logic [1:0]                          dma_offset,
  input  logic                                cpu_d_busy,
  input  logic                                cpu_d_we,
  input  logic [WORD_SIZE-1:0]                cpu_d_addr,
  input  logic [WORD_SIZE-1:0]                cpu_d_wdata,
  output logic                                cpu_stall,
  output logic                                mem_we,
  output logic [WORD_SIZE-1:0]                mem_addr,
  output logic [WORD_SIZE-1:0]                mem_wdata,
  output logic [CNT_W-1:0]                    lines_written,
  output logic                                overrun
);
  localparam int IDX_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, WAIT_CPU, GRANTED, RELEASE} state_t;

  state_t                              state_q;
  logic                                bg_q;
  logic                                stall_q;
  logic                                burst_q;
  logic                                seen_q;
  logic                                overrun_q;
  logic [IDX_W-1:0]                    idx_q;
  logic [1:0]                          last_off_q;
  logic [WORD_SIZE-1:0]                addr_q;
  logic [WORDS_PER_LINE*WORD_SIZE-1:0] data_q;
  logic [CNT_W-1:0]                    lines_q;
  logic [WORD_SIZE-1:0]                line_words [WORDS_PER_LINE];
  logic                                grant_start;
  logic                                new_line;
  logic                                burst_last;
  logic                                slot_free;

  assign grant_start = (state_q == IDLE || state_q == WAIT_CPU) && BR && !cpu_d_busy;
  assign new_line    = dma_write && (!seen_q || dma_offset != last_off_q);
  assign burst_last  = burst_q && (idx_q == LAST_IDX);
  // A capture may land on the edge that writes the final word, so bursts chain without a gap.
  assign slot_free   = !burst_q || burst_last;

  genvar gi;
  generate
    for (gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_word
      assign line_words[gi] = data_q[gi*WORD_SIZE +: WORD_SIZE];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= IDLE;
      bg_q       <= 1'b0;
      stall_q    <= 1'b0;
      burst_q    <= 1'b0;
      idx_q      <= '0;
      seen_q     <= 1'b0;
      last_off_q <= '0;
      lines_q    <= '0;
      overrun_q  <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else if (grant_start) begin
      state_q   <= GRANTED;
      bg_q      <= 1'b1;
      stall_q   <= 1'b1;
      burst_q   <= 1'b0;
      idx_q     <= '0;
      seen_q    <= 1'b0;
      lines_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE:     if (BR) state_q <= WAIT_CPU;
        WAIT_CPU: if (!BR) state_q <= IDLE;
        GRANTED: begin
          if (burst_q) begin
            idx_q <= idx_q + IDX_W'(1);
            if (burst_last) begin
              burst_q <= 1'b0;
              lines_q <= lines_q + CNT_W'(1);
            end
          end
          if (BR) begin
            // A dropped line still becomes the tracked offset, so holding it is not re-detected.
            if (new_line) begin
              seen_q     <= 1'b1;
              last_off_q <= dma_offset;
              if (slot_free) begin
                addr_q  <= dma_addr;
                data_q  <= dma_data;
                burst_q <= 1'b1;
                idx_q   <= '0;
              end else begin
                overrun_q <= 1'b1;
              end
            end
          end else if (slot_free) begin
            state_q <= RELEASE;
            bg_q    <= 1'b0;
          end
        end
        RELEASE: begin
          state_q <= IDLE;
          stall_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE, WAIT_CPU: begin
        mem_we    = cpu_d_we;
        mem_addr  = cpu_d_addr;
        mem_wdata = cpu_d_wdata;
      end
      GRANTED: begin
        if (burst_q) begin
          mem_we    = 1'b1;
          mem_addr  = addr_q + WORD_SIZE'(idx_q);
          mem_wdata = line_words[idx_q];
        end
      end
      default: ;
    endcase
  end

  assign BG            = bg_q;
  assign cpu_stall     = stall_q;
  assign lines_written = lines_q;
  assign overrun       = overrun_q;
endmodule

// File: tb/tb_dma_mem_bridge.sv
// Scoreboarded bench for dma_mem_bridge: a line-level model predicts burst writes,
// a negedge monitor pops and compares every DMA-owned memory write.
module tb_dma_mem_bridge;
  localparam int W   = 16;
  localparam int WPL = 4;
  localparam int CW  = 8;

  logic           CLK = 1'b0;
  logic           reset, BR, BG, dma_write, cpu_d_busy, cpu_d_we;
  logic           cpu_stall, mem_we, overrun;
  logic [W-1:0]   dma_addr, cpu_d_addr, cpu_d_wdata, mem_addr, mem_wdata;
  logic [WPL*W-1:0] dma_data;
  logic [1:0]     dma_offset;
  logic [CW-1:0]  lines_written;

  always #5 CLK = ~CLK;

  dma_mem_bridge #(.WORD_SIZE(W), .WORDS_PER_LINE(WPL), .CNT_W(CW)) dut (
    .CLK(CLK), .reset(reset), .BR(BR), .BG(BG), .dma_write(dma_write),
    .dma_addr(dma_addr), .dma_data(dma_data), .dma_offset(dma_offset),
    .cpu_d_busy(cpu_d_busy), .cpu_d_we(cpu_d_we), .cpu_d_addr(cpu_d_addr),
    .cpu_d_wdata(cpu_d_wdata), .cpu_stall(cpu_stall), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .lines_written(lines_written),
    .overrun(overrun)
  );

  typedef struct packed {
    logic [W-1:0] addr;
    logic [W-1:0] data;
  } wr_t;

  int  errors = 0;
  int  checks = 0;
  wr_t exp_q[$];
  wr_t mon_e;
  int  edge_n = 0;
  int  run_len = 0;
  int  max_run = 0;

  // line-level reference model state
  logic       m_seen;
  logic [1:0] m_last_off;
  int         m_last_cap;
  int         m_lines;
  logic       m_overrun;

  logic [1:0]     r_off;
  logic [W-1:0]   r_addr;
  logic [WPL*W-1:0] r_data;

  always @(posedge CLK) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (mem_we && cpu_stall) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr=%h data=%h expected no write", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        $display("write addr=%h data=%h (expected %h/%h)", mem_addr, mem_wdata, mon_e.addr, mon_e.data);
        check("burst_addr", mem_addr, mon_e.addr);
        check("burst_data", mem_wdata, mon_e.data);
      end
    end else begin
      run_len = 0;
    end
  end

  // Model: a line is new if its offset differs from the last one presented; it is
  // committed only if at least WPL edges have passed since the previous commit.
  task automatic dma_drive(input logic wr, input logic [1:0] off, input logic [W-1:0] a,
                           input logic [WPL*W-1:0] d);
    int  e;
    wr_t x;
    dma_write = wr; dma_offset = off; dma_addr = a; dma_data = d;
    e = edge_n + 1;
    if (BR && wr && (!m_seen || off != m_last_off)) begin
      m_seen = 1'b1;
      m_last_off = off;
      if (e - m_last_cap >= WPL) begin
        m_last_cap = e;
        m_lines++;
        for (int i = 0; i < WPL; i++) begin
          x.addr = W'(a + W'(i));
          x.data = d[i*W +: W];
          exp_q.push_back(x);
        end
      end else begin
        m_overrun = 1'b1;
      end
    end
    tick();
  endtask

  task automatic do_grant(input int busy_cycles);
    BR = 1'b1;
    cpu_d_busy = (busy_cycles > 0);
    for (int k = 0; k < busy_cycles; k++) begin
      cpu_d_addr = W'($urandom);
      tick();
      check("wait_bg", BG, 0);
      check("wait_stall", cpu_stall, 0);
      check("wait_pass_addr", mem_addr, cpu_d_addr);
    end
    cpu_d_busy = 1'b0;
    tick();
    check("grant_bg", BG, 1);
    check("grant_stall", cpu_stall, 1);
    m_seen = 1'b0; m_lines = 0; m_overrun = 1'b0; m_last_cap = -100;
  endtask

  task automatic do_release();
    int k;
    k = 0;
    BR = 1'b0;
    dma_write = 1'b0;
    do begin
      tick();
      k++;
    end while (BG && k < 20);
    check("release_bg", BG, 0);
    check("release_stall", cpu_stall, 1);
    check("release_no_we", mem_we, 0);
    check("release_drained", exp_q.size(), 0);
    check("lines_written", lines_written, m_lines & 255);
    check("overrun", overrun, m_overrun);
    tick();
    check("idle_stall", cpu_stall, 0);
    check("idle_pass_we", mem_we, cpu_d_we);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; BR = 1'b0; dma_write = 1'b0; dma_addr = '0; dma_data = '0;
    dma_offset = '0; cpu_d_busy = 1'b0; cpu_d_we = 1'b0; cpu_d_addr = '0; cpu_d_wdata = '0;
    tick();
    tick();
    check("rst_bg", BG, 0);
    check("rst_stall", cpu_stall, 0);
    check("rst_lines", lines_written, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;

    // CPU pass-through is combinational
    cpu_d_we = 1'b1; cpu_d_addr = 16'h0010; cpu_d_wdata = 16'hBEEF;
    #1;
    check("pass_we", mem_we, 1);
    check("pass_addr", mem_addr, 16'h0010);
    check("pass_data", mem_wdata, 16'hBEEF);
    check("pass_bg", BG, 0);
    tick();

    // BR withdrawn while waiting on the CPU: no grant
    BR = 1'b1; cpu_d_busy = 1'b1;
    tick();
    BR = 1'b0;
    tick();
    cpu_d_busy = 1'b0;
    tick();
    check("abort_bg", BG, 0);
    check("abort_stall", cpu_stall, 0);

    // three back-to-back lines after a 3-cycle CPU wait
    max_run = 0;
    do_grant(3);
    for (int off = 0; off < 3; off++) begin
      r_data = {16'(16'h4444 + off), 16'h3333, 16'h2222, 16'h1111};
      for (int k = 0; k < 4; k++) dma_drive(1'b1, 2'(off), 16'(16'h01F4 + 4*off), r_data);
    end
    do_release();
    check("full_gapless", max_run, 12);
    check("full_lines", lines_written, 3);
    check("full_overrun", overrun, 0);

    // offset changes one cycle after capture: dropped
    do_grant(0);
    dma_drive(1'b1, 2'd0, 16'h0200, {16'hA3, 16'hA2, 16'hA1, 16'hA0});
    for (int k = 0; k < 4; k++) dma_drive(1'b1, 2'd1, 16'h0204, {16'hB3, 16'hB2, 16'hB1, 16'hB0});
    do_release();
    check("ovr_lines", lines_written, 1);
    check("ovr_flag", overrun, 1);
    tick(); tick(); tick();
    check("hold_lines", lines_written, 1);
    check("hold_overrun", overrun, 1);

    // new offset arriving with two words still to go is also dropped
    do_grant(1);
    for (int k = 0; k < 3; k++) dma_drive(1'b1, 2'd2, 16'h0300, {16'hC3, 16'hC2, 16'hC1, 16'hC0});
    for (int k = 0; k < 4; k++) dma_drive(1'b1, 2'd3, 16'h0304, {16'hD3, 16'hD2, 16'hD1, 16'hD0});
    do_release();
    check("edge_ovr_flag", overrun, 1);

    // address wrap
    do_grant(0);
    dma_drive(1'b1, 2'd0, 16'hFFFE, {16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0A0A});
    do_release();
    check("wrap_lines", lines_written, 1);

    // randomized grants
    for (int g = 0; g < 6; g++) begin
      do_grant($urandom_range(2));
      r_off = 2'($urandom); r_addr = W'($urandom); r_data = {$urandom, $urandom};
      for (int c = 0; c < 24; c++) begin
        if ($urandom_range(3) == 0) begin
          r_off = 2'($urandom); r_addr = W'($urandom); r_data = {$urandom, $urandom};
        end
        cpu_d_we = 1'($urandom);
        cpu_d_addr = W'($urandom);
        dma_drive($urandom_range(4) != 0, r_off, r_addr, r_data);
      end
      do_release();
    end

    // reset in the middle of a burst
    cpu_d_we = 1'b0;
    do_grant(0);
    for (int k = 0; k < 4; k++) dma_drive(1'b1, 2'd0, 16'h0400, {16'hE3, 16'hE2, 16'hE1, 16'hE0});
    dma_drive(1'b1, 2'd1, 16'h0404, {16'hF3, 16'hF2, 16'hF1, 16'hF0});
    dma_drive(1'b0, 2'd1, 16'h0404, '0);
    dma_drive(1'b0, 2'd1, 16'h0404, '0);
    check("pre_rst_lines", lines_written, 1);
    reset = 1'b1; BR = 1'b0;
    cpu_d_we = 1'b1; cpu_d_addr = 16'h0123; cpu_d_wdata = 16'h5A5A;
    tick();
    exp_q.delete();
    check("midrst_we", mem_we, 1);
    check("midrst_addr", mem_addr, 16'h0123);
    check("midrst_data", mem_wdata, 16'h5A5A);
    check("midrst_bg", BG, 0);
    check("midrst_stall", cpu_stall, 0);
    check("midrst_lines", lines_written, 0);
    check("midrst_overrun", overrun, 0);
    reset = 1'b0;
    tick();
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
